// File: rtl/vector_issue_pkg.sv
// Shared types for the vector issue buffer: entry layout, FSM states and counter width.
package vector_issue_pkg;

  localparam int unsigned VIB_OUTST_W = 8;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] opa;
  } Vinst_entry;

  typedef enum logic [1:0] {
    VIB_RUN,
    VIB_DRAIN,
    VIB_ACK
  } Vib_state;

endpackage

// File: rtl/vib_fifo.sv
// Register-array FIFO for the vector issue buffer: wrap-bit pointers, occupancy and flush.
module vib_fifo
  import vector_issue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  Vinst_entry wdata,
  input  logic       pop,
  input  logic       flush,
  output Vinst_entry rdata,
  output logic       empty,
  output logic       full,
  output logic [AW:0] count
);

  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  Vinst_entry   mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         push_en;

  assign push_en = push & ~full;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_en) wr_ptr_d = wr_ptr_q + PtrOne;
    // Flush drops everything not yet issued by catching the read pointer up.
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end else if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/vector_issue_buffer.sv
// In-order issue buffer between the scalar core and the vector unit, with in-flight cap,
// sync drain handshake and flush of unissued entries.
module vector_issue_buffer
  import vector_issue_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_inst,
  input  logic [31:0]               in_opa,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_inst,
  output logic [31:0]               out_opa,
  input  logic                      done,
  input  logic                      sync_req,
  output logic                      sync_ack,
  input  logic                      flush,
  output logic [$clog2(DEPTH):0]    count,
  output logic [VIB_OUTST_W-1:0]    outstanding,
  output logic                      err_underflow
);

  localparam logic [VIB_OUTST_W-1:0] MaxOutst = VIB_OUTST_W'(MAX_OUTSTANDING);
  localparam logic [VIB_OUTST_W-1:0] OutstOne = VIB_OUTST_W'(1);

  Vib_state                state_q;
  logic                    sync_ack_q;
  logic [VIB_OUTST_W-1:0]  outst_q, outst_d;
  logic                    err_q, err_d;
  logic                    fifo_empty, fifo_full;
  logic                    accept, issue;
  Vinst_entry              wr_entry, head;

  // Reset gating keeps in_ready low while the block is held in reset.
  assign in_ready  = reset & (state_q == VIB_RUN) & ~fifo_full & ~flush;
  assign out_valid = ~fifo_empty & (outst_q < MaxOutst) & ~flush;
  assign accept    = in_valid & in_ready;
  assign issue     = out_valid & out_ready;

  assign wr_entry = '{inst: in_inst, opa: in_opa};

  vib_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .wdata (wr_entry),
    .pop   (issue),
    .flush (flush),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (count)
  );

  // Head is only exposed while it is being offered, so idle/reset outputs read as zero.
  assign out_inst = out_valid ? head.inst : 32'h0;
  assign out_opa  = out_valid ? head.opa  : 32'h0;

  always_comb begin
    outst_d = outst_q;
    err_d   = err_q;
    case ({issue, done})
      2'b10:   outst_d = outst_q + OutstOne;
      2'b01: begin
        if (outst_q == '0) err_d = 1'b1;
        else               outst_d = outst_q - OutstOne;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      outst_q <= outst_d;
      err_q   <= err_d;
    end
  end

  assign outstanding   = outst_q;
  assign err_underflow = err_q;

  // Drain completes on the cycle the last completion lands, so the ack follows it directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= VIB_RUN;
      sync_ack_q <= 1'b0;
    end else begin
      sync_ack_q <= 1'b0;
      case (state_q)
        VIB_RUN: begin
          if (sync_req) state_q <= VIB_DRAIN;
        end
        VIB_DRAIN: begin
          if (fifo_empty && (outst_d == '0)) begin
            state_q    <= VIB_ACK;
            sync_ack_q <= 1'b1;
          end
        end
        VIB_ACK: state_q <= VIB_RUN;
        default: state_q <= VIB_RUN;
      endcase
    end
  end

  assign sync_ack = sync_ack_q;

endmodule

// File: tb/tb_vector_issue_buffer.sv
// Self-checking bench for vector_issue_buffer against a queue-based reference model.
module tb_vector_issue_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_inst = '0, in_opa = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_inst, out_opa;
  logic        done = 1'b0, sync_req = 1'b0, sync_ack, flush = 1'b0;
  logic [2:0]  count;
  logic [7:0]  outstanding;
  logic        err_underflow;

  always #5 clk = ~clk;

  vector_issue_buffer #(
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_inst       (in_inst),
    .in_opa        (in_opa),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_opa       (out_opa),
    .done          (done),
    .sync_req      (sync_req),
    .sync_ack      (sync_ack),
    .flush         (flush),
    .count         (count),
    .outstanding   (outstanding),
    .err_underflow (err_underflow)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] opa;
  } ent_t;

  // Reference model: pending entries, in-flight count, sticky error, sync phase
  // (0 = normal, 1 = waiting for the pipe to empty, 2 = acknowledging).
  ent_t        q[$];
  int          m_out;
  bit          m_err;
  int          m_phase;
  bit          m_acc, m_iss;

  int          total = 0, bad = 0, ncyc = 0;
  logic [78:0] obs_vec, exp_vec;
  logic        obs_ov, obs_acc, obs_iss, obs_ack;
  logic [31:0] seen[$];

  task automatic model_clear();
    q.delete();
    m_out = 0; m_err = 0; m_phase = 0; m_acc = 0; m_iss = 0;
    seen.delete();
  endtask

  task automatic do_reset();
    in_valid = 0; out_ready = 0; done = 0; sync_req = 0; flush = 0;
    reset = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset = 1;
  endtask

  // One clock: predict outputs, sample DUT at negedge, advance model at posedge.
  task automatic cyc();
    logic        ev_in, ev_out, was_empty, sreq, dn, fl;
    logic [31:0] ei, eo, li, lo;
    ev_in  = reset && (m_phase == 0) && (q.size() < DEPTH) && !flush;
    ev_out = (q.size() > 0) && (m_out < MAXO) && !flush;
    ei = 32'h0; eo = 32'h0;
    if (ev_out) begin ei = q[0].inst; eo = q[0].opa; end
    @(negedge clk);
    exp_vec = {ev_in, ev_out, ei, eo, (m_phase == 2), 3'(q.size()), 8'(m_out), m_err};
    obs_vec = {in_ready, out_valid, out_inst, out_opa, sync_ack, count, outstanding,
               err_underflow};
    obs_ov  = out_valid;
    obs_acc = in_valid & in_ready;
    obs_iss = out_valid & out_ready;
    obs_ack = sync_ack;
    if (obs_iss) seen.push_back(out_inst);
    was_empty = (q.size() == 0);
    m_acc = in_valid && ev_in;
    m_iss = ev_out && out_ready;
    li = in_inst; lo = in_opa; sreq = sync_req; dn = done; fl = flush;
    @(posedge clk);
    if (m_iss) void'(q.pop_front());
    if (m_acc) q.push_back('{inst: li, opa: lo});
    if (fl) q.delete();
    if (m_iss && !dn) m_out++;
    else if (dn && !m_iss) begin
      if (m_out == 0) m_err = 1;
      else m_out--;
    end
    case (m_phase)
      0: if (sreq) m_phase = 1;
      1: if (was_empty && m_out == 0) m_phase = 2;
      default: m_phase = 0;
    endcase
    #1;
    ncyc++;
  endtask

  task automatic test_reset();
    reset = 0;
    #3;
    total++;
    if ({in_ready, out_valid, out_inst, out_opa, sync_ack, count, outstanding, err_underflow}
        !== 79'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {in_ready, out_valid, out_inst, out_opa,
               sync_ack, count, outstanding, err_underflow});
    end
    model_clear();
    @(posedge clk); #1 reset = 1;
    cyc();
    total++;
    if (obs_vec !== exp_vec) begin
      bad++; $display("FAIL reset_first_cycle got=%h want=%h", obs_vec, exp_vec);
    end
  endtask

  task automatic test_basic();
    int first_v = -1;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      in_valid = (c < 4); in_inst = 32'h1000_0001 + 32'(c); in_opa = $urandom;
      out_ready = 1; done = m_iss;
      cyc();
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("FAIL basic c=%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
      if (first_v < 0 && obs_ov) first_v = c;
    end
    in_valid = 0; done = 0;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] got;
      got = (k < seen.size()) ? seen[k] : 32'hxxxx_xxxx;
      total++;
      if (got !== 32'h1000_0001 + 32'(k)) begin
        bad++; $display("FAIL basic_order k=%0d got=%h want=%h", k, got, 32'h1000_0001 + k);
      end
    end
    total++;
    if (first_v != 1) begin bad++; $display("FAIL basic_latency got=%0d want=1", first_v); end
    total++;
    if (count !== 3'd0) begin bad++; $display("FAIL basic_count got=%0d want=0", count); end
  endtask

  task automatic test_full();
    int accs = 0;
    do_reset();
    out_ready = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1; in_inst = 32'h2000_0000 + 32'(c); in_opa = $urandom;
      cyc();
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("FAIL full c=%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
      if (obs_acc) accs++;
    end
    total++;
    if (accs != 4) begin bad++; $display("FAIL full_accepts got=%0d want=4", accs); end
    total++;
    if ({count, in_ready} !== {3'd4, 1'b0}) begin
      bad++; $display("FAIL full_ready got=%0d/%b want=4/0", count, in_ready);
    end
    out_ready = 1;
    cyc();
    total++;
    if ({obs_acc, obs_iss} !== 2'b01) begin
      bad++; $display("FAIL full_pop_no_room got=%b want=01", {obs_acc, obs_iss});
    end
    out_ready = 0;
    cyc();
    total++;
    if (obs_acc !== 1'b1) begin bad++; $display("FAIL full_next_accept got=%b want=1", obs_acc); end
    in_valid = 0;
  endtask

  task automatic test_outstanding();
    int pushed = 0;
    do_reset();
    out_ready = 1;
    for (int c = 0; c < 16; c++) begin
      in_valid = (pushed < 10); in_inst = 32'h3000_0000 + 32'(pushed); in_opa = $urandom;
      cyc();
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("FAIL outst c=%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
      if (obs_acc) pushed++;
    end
    in_valid = 0;
    total++;
    if ({8'(seen.size()), out_valid, count, outstanding} !== {8'd8, 1'b0, 3'd2, 8'd8}) begin
      bad++;
      $display("FAIL outst_cap got=%0d/%b/%0d/%0d want=8/0/2/8", seen.size(), out_valid,
               count, outstanding);
    end
    done = 1;
    cyc();
    total++;
    if (obs_ov !== 1'b0) begin bad++; $display("FAIL outst_done_cycle got=%b want=0", obs_ov); end
    done = 0;
    cyc();
    total++;
    if (seen.size() != 9 || seen[seen.size()-1] !== 32'h3000_0008) begin
      bad++; $display("FAIL outst_ninth got=%0d want=9", seen.size());
    end
    done = 1;
    cyc();
    cyc();  // issue and done together in this cycle
    done = 0;
    total++;
    if (outstanding !== 8'd7 || seen.size() != 10) begin
      bad++; $display("FAIL outst_same_cycle got=%0d/%0d want=7/10", outstanding, seen.size());
    end
  endtask

  task automatic test_sync();
    int ack_c = -1, last_done = -1, nacks = 0, drain_acc = 0, ack_snap = -1;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      in_valid  = (c < 2) || (c >= 3 && c < 6) || (c >= 7);
      out_ready = (c < 3) || (c >= 7);
      in_inst = $urandom; in_opa = $urandom;
      if (c == 6) sync_req = 1;
      done = (c >= 10) && (c % 2 == 0) && (m_out > 0);
      if (done && ack_c < 0) last_done = c;
      cyc();
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("FAIL sync c=%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
      if (c > 6 && ack_c < 0 && obs_acc) drain_acc++;
      if (obs_ack) begin
        nacks++;
        if (ack_c < 0) begin ack_c = c; ack_snap = int'(obs_vec[11:1]); end
        sync_req = 0;
      end
    end
    done = 0; in_valid = 0;
    total++;
    if (ack_c != last_done + 1 || ack_c < 0) begin
      bad++; $display("FAIL sync_ack_timing got=%0d want=%0d", ack_c, last_done + 1);
    end
    total++;
    if (nacks != 1) begin bad++; $display("FAIL sync_ack_count got=%0d want=1", nacks); end
    total++;
    if (drain_acc != 0) begin bad++; $display("FAIL sync_no_accept got=%0d want=0", drain_acc); end
    total++;
    if (ack_snap != 0) begin bad++; $display("FAIL sync_ack_idle got=%0d want=0", ack_snap); end
    // Drain request on an already idle buffer.
    do_reset();
    ack_c = -1;
    sync_req = 1;
    for (int c = 0; c < 6; c++) begin
      cyc();
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("FAIL sync_idle c=%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
      if (obs_ack) begin
        if (ack_c < 0) ack_c = c;
        sync_req = 0;
      end
    end
    total++;
    if (ack_c != 2) begin bad++; $display("FAIL sync_idle_latency got=%0d want=2", ack_c); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int c = 0; c < 9; c++) begin
      in_valid  = (c == 0) || (c >= 2 && c <= 5) || (c == 7);
      out_ready = (c <= 1) || (c >= 5);
      flush     = (c == 5);
      in_inst   = (c == 7) ? 32'h5000_00AA : 32'h5000_0000 + 32'(c);
      in_opa    = $urandom;
      cyc();
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("FAIL flush c=%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
      if (c == 5) begin
        total++;
        if ({obs_ov, obs_acc} !== 2'b00) begin
          bad++; $display("FAIL flush_cycle got=%b want=00", {obs_ov, obs_acc});
        end
      end
      if (c == 6) begin
        total++;
        if ({obs_vec[11:1], obs_ov} !== {3'd0, 8'd1, 1'b0}) begin
          bad++; $display("FAIL flush_after got=%h want=%h", {obs_vec[11:1], obs_ov},
                          {3'd0, 8'd1, 1'b0});
        end
      end
    end
    flush = 0; in_valid = 0;
    total++;
    if (seen.size() != 2 || seen[seen.size()-1] !== 32'h5000_00AA || outstanding !== 8'd2) begin
      bad++; $display("FAIL flush_repush got=%0d/%0d want=2/2", seen.size(), outstanding);
    end
  endtask

  task automatic test_underflow_reset();
    do_reset();
    done = 1;
    cyc();
    done = 0;
    out_ready = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1; in_inst = $urandom; in_opa = $urandom;
      cyc();
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("FAIL underflow c=%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
    end
    total++;
    if (err_underflow !== 1'b1) begin
      bad++; $display("FAIL underflow_sticky got=%b want=1", err_underflow);
    end
    out_ready = 1;
    #1 reset = 0;
    #1;
    total++;
    if ({in_ready, out_valid, out_inst, out_opa, sync_ack, count, outstanding, err_underflow}
        !== 79'h0) begin
      bad++;
      $display("FAIL async_reset got=%h want=0", {in_ready, out_valid, out_inst, out_opa,
               sync_ack, count, outstanding, err_underflow});
    end
    in_valid = 0; out_ready = 0;
    model_clear();
    @(posedge clk); #1 reset = 1;
    cyc();
    total++;
    if (obs_vec !== exp_vec) begin
      bad++; $display("FAIL post_reset got=%h want=%h", obs_vec, exp_vec);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom % 3) != 0;
      in_inst   = $urandom; in_opa = $urandom;
      out_ready = ($urandom % 4) != 0;
      done      = (m_out > 0) && (($urandom % 3) == 0);
      flush     = ($urandom % 40) == 0;
      if (!sync_req && ($urandom % 30) == 0) sync_req = 1;
      cyc();
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("FAIL random c=%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
      if (obs_ack) sync_req = 0;
    end
    in_valid = 0; out_ready = 0; done = 0; flush = 0; sync_req = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_outstanding();
    test_sync();
    test_flush();
    test_underflow_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
